// File: rtl/pipe_arb.sv
// Two-requester round-robin front end feeding a stalling pipeline that computes
// F = ((A+B) + (C-D)) * D mod 2^N; the result appears three edges after acceptance.
module pipe_arb #(
  parameter int unsigned N = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [N-1:0] req0_a,
  input  logic [N-1:0] req0_b,
  input  logic [N-1:0] req0_c,
  input  logic [N-1:0] req0_d,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [N-1:0] req1_a,
  input  logic [N-1:0] req1_b,
  input  logic [N-1:0] req1_c,
  input  logic [N-1:0] req1_d,
  output logic         res_valid,
  input  logic         res_ready,
  output logic [N-1:0] res_f,
  output logic         res_id,
  output logic         busy
);

  logic         advance;
  logic         grant;
  logic         accept;
  logic         lg_q;

  // Operand register: the arithmetic only ever sees captured operands.
  logic         s0_v_q, s0_id_q;
  logic [N-1:0] s0_a_q, s0_b_q, s0_c_q, s0_d_q;
  logic [N-1:0] in_a, in_b, in_c, in_d;

  logic         s1_v_q, s1_id_q;
  logic [N-1:0] s1_x1_q, s1_x2_q, s1_d_q;
  logic [N-1:0] s1_x1_d, s1_x2_d;

  logic         s2_v_q, s2_id_q;
  logic [N-1:0] s2_x3_q, s2_d_q;
  logic [N-1:0] s2_x3_d;

  logic         s3_v_q, s3_id_q;
  logic [N-1:0] s3_f_q;
  logic [N-1:0] s3_f_d;

  always_comb begin
    advance = !s3_v_q || res_ready;
    // On a tie the requester that did not win last time goes next.
    if (req0_valid && req1_valid) begin
      grant = ~lg_q;
    end else begin
      grant = req1_valid;
    end
    req0_ready = rst_n && advance && req0_valid && !grant;
    req1_ready = rst_n && advance && req1_valid && grant;
    accept     = req0_ready || req1_ready;

    in_a = grant ? req1_a : req0_a;
    in_b = grant ? req1_b : req0_b;
    in_c = grant ? req1_c : req0_c;
    in_d = grant ? req1_d : req0_d;

    s1_x1_d = s0_a_q + s0_b_q;
    s1_x2_d = s0_c_q - s0_d_q;
    s2_x3_d = s1_x1_q + s1_x2_q;
    s3_f_d  = s2_x3_q * s2_d_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lg_q    <= 1'b1;
      s0_v_q  <= 1'b0;
      s0_id_q <= 1'b0;
      s0_a_q  <= '0;
      s0_b_q  <= '0;
      s0_c_q  <= '0;
      s0_d_q  <= '0;
      s1_v_q  <= 1'b0;
      s1_id_q <= 1'b0;
      s1_x1_q <= '0;
      s1_x2_q <= '0;
      s1_d_q  <= '0;
      s2_v_q  <= 1'b0;
      s2_id_q <= 1'b0;
      s2_x3_q <= '0;
      s2_d_q  <= '0;
      s3_v_q  <= 1'b0;
      s3_id_q <= 1'b0;
      s3_f_q  <= '0;
    end else if (advance) begin
      if (accept) begin
        lg_q <= grant;
      end
      s0_v_q  <= accept;
      s0_id_q <= grant;
      s0_a_q  <= in_a;
      s0_b_q  <= in_b;
      s0_c_q  <= in_c;
      s0_d_q  <= in_d;
      s1_v_q  <= s0_v_q;
      s1_id_q <= s0_id_q;
      s1_x1_q <= s1_x1_d;
      s1_x2_q <= s1_x2_d;
      s1_d_q  <= s0_d_q;
      s2_v_q  <= s1_v_q;
      s2_id_q <= s1_id_q;
      s2_x3_q <= s2_x3_d;
      s2_d_q  <= s1_d_q;
      s3_v_q  <= s2_v_q;
      s3_id_q <= s2_id_q;
      s3_f_q  <= s3_f_d;
    end
  end

  assign res_valid = s3_v_q;
  assign res_f     = s3_f_q;
  assign res_id    = s3_id_q;
  assign busy      = s0_v_q || s1_v_q || s2_v_q || s3_v_q;

endmodule

// File: tb/tb_pipe_arb.sv
// Directed bench for pipe_arb: hand-computed results for single ops, wrap,
// round-robin ties, backpressure, per-op D capture and mid-flight reset.
module tb_pipe_arb;
  localparam int unsigned N = 10;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         req0_valid, req0_ready;
  logic [N-1:0] req0_a, req0_b, req0_c, req0_d;
  logic         req1_valid, req1_ready;
  logic [N-1:0] req1_a, req1_b, req1_c, req1_d;
  logic         res_valid, res_ready, res_id, busy;
  logic [N-1:0] res_f;

  int n_cmp = 0;
  int n_bad = 0;

  pipe_arb #(.N(N)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_c     (req0_c),
    .req0_d     (req0_d),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_c     (req1_c),
    .req1_d     (req1_d),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_f      (res_f),
    .res_id     (res_id),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic set0(input logic v, input int a, input int b, input int c, input int d);
    req0_valid = v;
    req0_a = N'(a); req0_b = N'(b); req0_c = N'(c); req0_d = N'(d);
  endtask

  task automatic set1(input logic v, input int a, input int b, input int c, input int d);
    req1_valid = v;
    req1_a = N'(a); req1_b = N'(b); req1_c = N'(c); req1_d = N'(d);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [N-1:0] tie_f [4];
    logic [N-1:0] bp_f  [3];
    logic [N-1:0] dv_f  [3];
    tie_f = '{10'd2, 10'd5, 10'd2, 10'd5};
    bp_f  = '{10'd5, 10'd15, 10'd50};
    dv_f  = '{10'd1023, 10'd1020, 10'd1015};

    rst_n = 1'b0;
    res_ready = 1'b1;
    set0(1'b1, 0, 0, 0, 0);
    set1(1'b1, 0, 0, 0, 0);
    @(negedge clk);
    #1;
    chk("rst_res_valid", res_valid, 0);
    chk("rst_res_f", res_f, 0);
    chk("rst_res_id", res_id, 0);
    chk("rst_busy", busy, 0);
    chk("rst_req0_ready", req0_ready, 0);
    chk("rst_req1_ready", req1_ready, 0);
    set1(1'b0, 0, 0, 0, 0);

    // Single op from requester 0.
    @(negedge clk);
    rst_n = 1'b1;
    set0(1'b1, 3, 4, 10, 2);
    #1;
    chk("single_req0_ready", req0_ready, 1);
    chk("single_req1_ready", req1_ready, 0);
    @(negedge clk);
    set0(1'b0, 0, 0, 0, 0);
    chk("single_lat1", res_valid, 0);
    @(negedge clk);
    chk("single_busy", busy, 1);
    @(negedge clk);
    chk("single_lat3", res_valid, 0);
    @(negedge clk);
    chk("single_valid", res_valid, 1);
    chk("single_f", res_f, 30);
    chk("single_id", res_id, 0);
    @(negedge clk);
    chk("single_drain", res_valid, 0);
    chk("single_idle", busy, 0);

    // Wrap-around through requester 1.
    set1(1'b1, 600, 600, 0, 2);
    #1;
    chk("wrap_req1_ready", req1_ready, 1);
    chk("wrap_req0_ready", req0_ready, 0);
    @(negedge clk);
    set1(1'b0, 0, 0, 0, 0);
    repeat (2) @(negedge clk);
    chk("wrap_lat", res_valid, 0);
    @(negedge clk);
    chk("wrap_valid", res_valid, 1);
    chk("wrap_f", res_f, 348);
    chk("wrap_id", res_id, 1);

    // Tie right after reset: grants alternate starting with requester 0.
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i <= 8; i++) begin
      if (i > 0) @(negedge clk);
      if (i >= 4 && i < 8) begin
        chk($sformatf("tie_valid%0d", i - 4), res_valid, 1);
        chk($sformatf("tie_f%0d", i - 4), res_f, tie_f[i-4]);
        chk($sformatf("tie_id%0d", i - 4), res_id, (i - 4) % 2);
      end
      if (i == 8) chk("tie_drain", res_valid, 0);
      set0(i < 4, 1, 1, 1, 1);
      set1(i < 4, 2, 2, 2, 1);
      #1;
      if (i < 4) begin
        chk($sformatf("tie_g0_%0d", i), req0_ready, (i % 2) == 0);
        chk($sformatf("tie_g1_%0d", i), req1_ready, (i % 2) == 1);
      end
    end

    // Backpressure: three ops, result consumer stalls for five cycles.
    for (int i = 0; i <= 12; i++) begin
      @(negedge clk);
      if (i < 3) begin
        case (i)
          0: set0(1'b1, 1, 2, 3, 1);
          1: set0(1'b1, 4, 4, 0, 3);
          default: set0(1'b1, 10, 0, 5, 5);
        endcase
        #1;
        chk($sformatf("bp_acc%0d", i), req0_ready, 1);
      end else if (i == 3) begin
        set0(1'b0, 0, 0, 0, 0);
      end else if (i == 4) begin
        chk("bp_first_valid", res_valid, 1);
        chk("bp_first_f", res_f, bp_f[0]);
        res_ready = 1'b0;
      end else if (i <= 8) begin
        chk($sformatf("bp_hold_v%0d", i), res_valid, 1);
        chk($sformatf("bp_hold_f%0d", i), res_f, bp_f[0]);
        set0(1'b1, 7, 7, 7, 7);
        set1(1'b1, 7, 7, 7, 7);
        #1;
        chk($sformatf("bp_r0_%0d", i), req0_ready, 0);
        chk($sformatf("bp_r1_%0d", i), req1_ready, 0);
      end else if (i == 9) begin
        chk("bp_last_hold", res_f, bp_f[0]);
        set0(1'b0, 0, 0, 0, 0);
        set1(1'b0, 0, 0, 0, 0);
        res_ready = 1'b1;
      end else if (i <= 11) begin
        chk($sformatf("bp_next_v%0d", i), res_valid, 1);
        chk($sformatf("bp_next_f%0d", i), res_f, bp_f[i-9]);
        chk($sformatf("bp_next_id%0d", i), res_id, 0);
      end else begin
        chk("bp_no_dup", res_valid, 0);
      end
    end

    // D changes every op; each result must use its own captured D.
    for (int i = 0; i <= 7; i++) begin
      @(negedge clk);
      if (i >= 4 && i < 7) begin
        chk($sformatf("dv_valid%0d", i - 4), res_valid, 1);
        chk($sformatf("dv_f%0d", i - 4), res_f, dv_f[i-4]);
      end
      if (i == 7) chk("dv_drain", res_valid, 0);
      if (i < 3) set0(1'b1, 0, 0, 0, i + 1);
      else set0(1'b0, 0, 0, 0, 0);
    end

    // Reset with two ops in flight discards both.
    for (int i = 0; i <= 4; i++) begin
      @(negedge clk);
      case (i)
        0: set0(1'b1, 3, 4, 10, 2);
        1: set0(1'b1, 0, 0, 0, 1);
        default: set0(1'b0, 0, 0, 0, 0);
      endcase
    end
    chk("mid_pre_valid", res_valid, 1);
    chk("mid_pre_f", res_f, 30);
    #2;
    rst_n = 1'b0;
    req0_valid = 1'b1;
    #1;
    chk("mid_valid_clr", res_valid, 0);
    chk("mid_f_clr", res_f, 0);
    chk("mid_busy_clr", busy, 0);
    chk("mid_ready_clr", req0_ready, 0);
    req0_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk($sformatf("mid_quiet%0d", i), res_valid, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/pipe_arb.md
PIPE_ARB -- requirements
Module: pipe_arb

Interface
REQ-001 The module SHALL have parameter N, default 10, giving the operand and result width in bits.
REQ-002 Port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 Port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 Port req0_valid  input  1  requester 0 presents an operation.
REQ-005 Port req0_ready  output  1  requester 0 operation accepted this cycle.
REQ-006 Port req0_a, req0_b, req0_c, req0_d  input  N each  requester 0 operands A, B, C, D.
REQ-007 Port req1_valid  input  1  requester 1 presents an operation.
REQ-008 Port req1_ready  output  1  requester 1 operation accepted this cycle.
REQ-009 Port req1_a, req1_b, req1_c, req1_d  input  N each  requester 1 operands A, B, C, D.
REQ-010 Port res_valid  output  1  result present.
REQ-011 Port res_ready  input  1  consumer takes the result.
REQ-012 Port res_f  output  N  result F.
REQ-013 Port res_id  output  1  id of the requester that issued the result.
REQ-014 Port busy  output  1  high while any pipeline stage holds a valid operation.

Function
REQ-015 A transfer SHALL occur on a channel when valid and ready are both high at a rising clk edge.
REQ-016 The block SHALL compute F = ((A+B) + (C-D)) * D, modulo 2^N, as a three-stage pipeline.
  - S1: x1 = A+B, x2 = C-D, D forwarded.
  - S2: x3 = x1+x2, D forwarded.
  - S3: F = x3*D.
REQ-017 Every stage SHALL carry a valid bit, the requester id, and the D captured with that operation; S3 SHALL never use a live input D.
REQ-018 Every intermediate value SHALL be truncated to N bits, and every result SHALL be the low N bits of the product.
REQ-019 The pipeline SHALL use advance = !res_valid || res_ready.
  - All stages shift together when advance is high.
  - All stages hold when advance is low.
REQ-020 An operation accepted at edge k SHALL appear on res_valid/res_f/res_id after edge k+3, provided advance stays high.
REQ-021 At most one request SHALL be granted per cycle, and req0_ready and req1_ready SHALL never both be high.
REQ-022 reqX_ready SHALL be combinational: advance && reqX_valid && grant==X. It SHALL not depend on res_valid of the same cycle other than through advance.
REQ-023 Arbitration SHALL be round-robin using a last-granted pointer lg.
  - Only one requester valid: that requester wins.
  - Both valid: the requester != lg wins.
  - lg SHALL update only on an accepted transfer.
REQ-024 When advance is low, both ready outputs SHALL be low and lg SHALL hold.
REQ-025 When advance is high and no request is accepted, a bubble (valid=0) SHALL enter S1.
REQ-026 res_f and res_id SHALL be driven from the S3 registers and SHALL remain stable while res_valid && !res_ready.
REQ-027 Sustained throughput SHALL be one operation per cycle while res_ready is held high.
REQ-028 busy SHALL be the OR of the S1, S2 and S3 valid bits.

Reset
REQ-029 While rst_n is low, the block SHALL immediately clear all stage valid bits.
  - res_valid = 0, res_f = 0, res_id = 0, busy = 0.
  - Both ready outputs = 0.
  - lg = 1, so requester 0 wins the first tie.
REQ-030 An assertion of rst_n mid-operation SHALL discard all in-flight operations, and no result SHALL be produced for them after release.
REQ-031 The first acceptance SHALL occur no earlier than the first rising edge after rst_n deasserts.

Verification
REQ-032 Single op: req0 A=3, B=4, C=10, D=2, res_ready=1 -> res_valid three edges later, res_f=30, res_id=0.
REQ-033 Wrap: req1 A=600, B=600, C=0, D=2 (N=10) -> res_f=348, res_id=1.
REQ-034 Tie, both valid for 4 cycles after reset -> grants in order 0,1,0,1, and results return in that order with matching ids.
REQ-035 Backpressure: three back-to-back ops, res_ready=0 for 5 cycles after the first result.
  - Both ready outputs low while stalled.
  - res_f stable while stalled.
  - No op lost or duplicated.
  - Order preserved after res_ready=1.
REQ-036 Operand D differs each cycle (D = 1, 2, 3 with A=B=C=0) -> results -1*1, -2*2, -3*3 mod 1024 = 1023, 1020, 1015.
REQ-037 rst_n pulsed low with two ops in flight -> outputs clear asynchronously, and no res_valid appears afterward without new requests.
